// File: rtl/spi_slave_rx_mode0.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave receiver. Synchronises CS_n/SCLK/MOSI into
// In_clk, shifts MOSI in MSB first on SCLK rise and reports words and frame status.
module spi_slave_rx_mode0 #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  In_clk,
  input  logic                  In_rst,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic [DATA_WIDTH-1:0] Out_rx_data,
  output logic                  Out_rx_valid,
  output logic                  Out_rx_busy,
  output logic                  Out_frame_done,
  output logic                  Out_frame_err,
  output logic [7:0]            Out_byte_cnt,
  output logic                  Out_dbg_state
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_hist, sclk_hist;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_rise;

  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  shift_nxt;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   word_done;
  logic                   start_frame;
  logic                   end_frame;
  logic                   take_bit;

  // Sync and history flops reset to 0, so CS held low across reset is not a fall.
  always_ff @(posedge In_clk) begin
    if (In_rst) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_hist   <= 1'b0;
      sclk_hist <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], In_spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], In_spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], In_spi_mosi};
      cs_hist   <= cs_sync[SYNC_STAGES-1];
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_hist;
  assign cs_rise   = cs_s & ~cs_hist;
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign shift_nxt = {shift_q[DATA_WIDTH-2:0], mosi_s};

  // Next-state and event decode; a CS rise masks a coincident SCLK rise.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    take_bit    = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = RECV;
          start_frame = 1'b1;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else if (sclk_rise) begin
          take_bit  = 1'b1;
          word_done = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge In_clk) begin
    if (In_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge In_clk) begin
    if (In_rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      Out_rx_data    <= '0;
      Out_rx_valid   <= 1'b0;
      Out_frame_done <= 1'b0;
      Out_frame_err  <= 1'b0;
      Out_byte_cnt   <= '0;
    end else begin
      Out_rx_valid   <= 1'b0;
      Out_frame_done <= 1'b0;
      Out_frame_err  <= 1'b0;
      if (start_frame) begin
        shift_q      <= '0;
        bit_cnt_q    <= '0;
        Out_byte_cnt <= '0;
      end else if (end_frame) begin
        Out_frame_done <= 1'b1;
        Out_frame_err  <= (bit_cnt_q != '0);
        bit_cnt_q      <= '0;
      end else if (take_bit) begin
        shift_q <= shift_nxt;
        if (word_done) begin
          bit_cnt_q    <= '0;
          Out_rx_data  <= shift_nxt;
          Out_rx_valid <= 1'b1;
          if (Out_byte_cnt != 8'hFF) Out_byte_cnt <= Out_byte_cnt + 8'd1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign Out_rx_busy   = (state_q == RECV);
  assign Out_dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_rx_mode0.sv
// Bench for spi_slave_rx_mode0: directed SPI frames, scoreboard queues for
// received words and frame-end status, drained by a monitor on the falling edge.
module tb_spi_slave_rx_mode0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst, cs_n, sclk, mosi;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_done, frame_err, dbg_state;
  logic [7:0] byte_cnt;

  spi_slave_rx_mode0 #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .In_clk         (clk),
    .In_rst         (rst),
    .In_spi_cs_n    (cs_n),
    .In_spi_sclk    (sclk),
    .In_spi_mosi    (mosi),
    .Out_rx_data    (rx_data),
    .Out_rx_valid   (rx_valid),
    .Out_rx_busy    (rx_busy),
    .Out_frame_done (frame_done),
    .Out_frame_err  (frame_err),
    .Out_byte_cnt   (byte_cnt),
    .Out_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [8:0] exp_frame_q[$];   // {err, byte_cnt}
  logic       busy_watch   = 1'b0;
  int         busy_hits    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) report_unexpected("unexpected_rx_valid", 32'(rx_data));
        else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_done) begin
        if (exp_frame_q.size() == 0) begin
          report_unexpected("unexpected_frame_done", 32'(byte_cnt));
        end else begin
          logic [8:0] ef;
          ef = exp_frame_q.pop_front();
          check("frame_err", 32'(frame_err), 32'(ef[8]));
          check("frame_byte_cnt", 32'(byte_cnt), 32'(ef[7:0]));
        end
      end
      if (frame_err && !frame_done) report_unexpected("frame_err_without_done", 32'(frame_err));
      if (busy_watch && rx_busy) busy_hits++;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int h);
    mosi = b;
    wait_clk(h);
    sclk = 1'b1;
    wait_clk(h);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int h);
    for (int i = 7; i >= 0; i--) send_bit(d[i], h);
  endtask

  task automatic cs_open();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_close();
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bytes4 [4];
    logic [7:0] c5;
    bytes4 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    c5     = 8'hA8;

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_byte_cnt", 32'(byte_cnt), 32'h0);
    wait_clk(6);

    // Two single-byte frames
    exp_q.push_back(8'h12); exp_frame_q.push_back({1'b0, 8'd1});
    cs_open();
    check("busy_in_frame", 32'(rx_busy), 32'h1);
    send_byte(8'h12, 6);
    cs_close();
    check("busy_after_frame", 32'(rx_busy), 32'h0);
    exp_q.push_back(8'h55); exp_frame_q.push_back({1'b0, 8'd1});
    cs_open(); send_byte(8'h55, 6); cs_close();

    // Four words in one frame
    foreach (bytes4[i]) exp_q.push_back(bytes4[i]);
    exp_frame_q.push_back({1'b0, 8'd4});
    cs_open();
    foreach (bytes4[i]) send_byte(bytes4[i], 6);
    cs_close();
    check("byte_cnt_held", 32'(byte_cnt), 32'd4);

    // Full word then partial word
    exp_q.push_back(8'hC3); exp_frame_q.push_back({1'b1, 8'd1});
    cs_open();
    send_byte(8'hC3, 6);
    for (int i = 7; i >= 3; i--) send_bit(c5[i], 6);
    cs_close();
    check("partial_rx_data_held", 32'(rx_data), 32'hC3);
    check("partial_byte_cnt", 32'(byte_cnt), 32'd1);

    // SCLK activity with CS high is ignored
    busy_watch = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(i[0], 4);
    wait_clk(8);
    busy_watch = 1'b0;
    check("cs_high_busy_hits", 32'(busy_hits), 32'd0);
    check("cs_high_rx_data", 32'(rx_data), 32'hC3);
    check("cs_high_byte_cnt", 32'(byte_cnt), 32'd1);

    // Reset mid-frame with CS held low
    cs_open();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 6);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    send_byte(8'hF0, 6);
    wait_clk(6);
    check("after_rst_busy", 32'(rx_busy), 32'h0);
    check("after_rst_state", 32'(dbg_state), 32'h0);
    check("after_rst_byte_cnt", 32'(byte_cnt), 32'h0);
    check("after_rst_rx_data", 32'(rx_data), 32'h0);
    cs_n = 1'b1;
    wait_clk(8);
    exp_q.push_back(8'h81); exp_frame_q.push_back({1'b0, 8'd1});
    cs_open(); send_byte(8'h81, 6); cs_close();

    // CS rise coincident with the 8th SCLK rise
    exp_frame_q.push_back({1'b1, 8'd0});
    cs_open();
    for (int i = 0; i < 7; i++) send_bit(1'b0, 6);
    mosi = 1'b1;
    wait_clk(6);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clk(6);
    sclk = 1'b0;
    wait_clk(8);
    check("collision_rx_data", 32'(rx_data), 32'h81);
    check("collision_byte_cnt", 32'(byte_cnt), 32'd0);

    // 256 words in one frame: byte count saturates at 255
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i * 7 + 3));
    exp_frame_q.push_back({1'b0, 8'd255});
    cs_open();
    for (int i = 0; i < 256; i++) send_byte(8'(i * 7 + 3), 3);
    cs_close();
    check("sat_byte_cnt", 32'(byte_cnt), 32'd255);

    wait_clk(20);
    check("data_queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_queue_drained", 32'(exp_frame_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
